// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I load/store constants and data-memory responder
// state encoding.
//   F3_*          : funct3 size/sign codes for loads and stores
//   dmem_state_t  : responder FSM states
//   byte_enables  : lane mask for a naturally aligned access of a given size
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_t;

    // Lane mask for the access. Halfwords use addr[1] only; the misaligned
    // case is rejected by the caller before the mask is used.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram -- DEPTH_WORDS x 32 synchronous storage, byte-enable write,
// registered read, no reset (contents survive reset).
//   clk   : clock
//   be    : per-byte write enables (bit i writes wdata[8i+7:8i])
//   addr  : word index, shared by read and write
//   wdata : write data, already replicated onto the enabled lanes
//   rdata : mem[addr] as of the previous rising edge
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- RV32I data-memory responder with fixed wait states.
// One request at a time: IDLE accepts, WAIT counts WAIT_CYCLES down, the
// WAIT->RESP edge commits the store or captures the load, RESP holds the
// response until rsp_ready.
//   clk, rst                : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we/addr/wdata/funct3: store flag, byte address, right-aligned data, size
//   rsp_valid/rsp_ready     : response handshake (valid only in RESP)
//   rsp_rdata               : extended load data, 0 for stores and errors
//   rsp_err                 : misaligned, out of range or illegal funct3
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t state, state_nxt;

    logic [3:0]    wait_cnt;
    logic          ready_en;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_f3;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          accept;
    logic          commit;
    logic          acc_err;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_q;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    // ready_en holds req_ready low during reset and rises one edge after release
    assign req_ready = ready_en && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid && req_ready;
    assign commit    = (state == ST_WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_WAIT;
            ST_WAIT: if (commit)    state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en    <= 1'b0;
            wait_cnt    <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_f3      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_f3    <= req_funct3;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == ST_WAIT) && !commit) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || lat_we) ? '0 : load_val;
            end
        end
    end

    always_comb begin
        acc_err = 1'b0;
        case (lat_f3)
            F3_B:    acc_err = 1'b0;
            F3_BU:   acc_err = lat_we;
            F3_H:    acc_err = lat_addr[0];
            F3_HU:   acc_err = lat_addr[0] || lat_we;
            F3_W:    acc_err = (lat_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (lat_addr[31:2] >= DEPTH_LIM) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        mem_wdata = lat_wdata;
        case (lat_f3)
            F3_B:    mem_wdata = {4{lat_wdata[7:0]}};
            F3_H:    mem_wdata = {2{lat_wdata[15:0]}};
            default: mem_wdata = lat_wdata;
        endcase
        mem_be = (commit && lat_we && !acc_err) ? byte_enables(lat_f3, lat_addr[1:0]) : 4'b0000;
    end

    // Read index follows the incoming request in IDLE so the registered read
    // is already valid on the commit edge even with zero wait states.
    assign mem_idx = (state == ST_IDLE) ? req_addr[AW+1:2] : lat_addr[AW+1:2];

    always_comb begin
        shifted  = mem_q >> {lat_addr[1:0], 3'b000};
        load_val = '0;
        case (lat_f3)
            F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_val = {24'd0, shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_val = {16'd0, shifted[15:0]};
            F3_W:    load_val = mem_q;
            default: load_val = '0;
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk  (clk),
        .be   (mem_be),
        .addr (mem_idx),
        .wdata(mem_wdata),
        .rdata(mem_q)
    );

endmodule
